alu_mdu_seq: RTL
================

// Module: alu_mdu_seq
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle RV32I execute ALU.
//  Adds the RV32M multiply/divide ops, a registered result with valid/ready flow control,
//  and an illegal-op flag. It sits between decode/issue and writeback in the execute stage.
// PARAMETERS
//  XLEN      32   operand/result width; must be a power of two, >= 8
//  SHAMT_W   $clog2(XLEN)   shift-amount bits taken from operand2[SHAMT_W-1:0]
// PORTS
//  clk          in   1     sole clock; rising edge
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     request valid
//  in_ready     out  1     block can accept a request this cycle
//  operand1     in   XLEN  rs1 value
//  operand2     in   XLEN  rs2 / immediate value
//  funct7       in   7     RISC-V funct7
//  funct3       in   3     RISC-V funct3
//  out_valid    out  1     result valid
//  out_ready    in   1     consumer accepts result
//  result       out  XLEN  operation result
//  out_illegal  out  1     {funct7,funct3} not supported; result is 0
// BEHAVIOUR
//  - Reset: out_valid=0, result=0, out_illegal=0, state=IDLE, divider counter=0; in_ready=1 on the cycle after reset.
//    Reset mid-divide aborts the operation; no result is produced.
//  - Accept: in_valid && in_ready at a rising edge.
//    in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back 1-cycle ops sustain 1 op/clk.
//  - Output register holds result/out_illegal stable while out_valid && !out_ready.
//  - funct7=0000000/0100000: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND, with the RV32I encodings.
//    Shifts mask to SHAMT_W bits. SLT/SLTU produce zero-extended 0/1.
//  - funct7=0000001: MUL MULH MULHSU MULHU (f3 0-3), DIV DIVU REM REMU (f3 4-7).
//    MUL returns the low XLEN bits of the product. MULH* return the high XLEN bits of the 2*XLEN signed/unsigned/mixed product.
//  - Latency: ALU and MUL ops set out_valid at the first edge after accept (1 cycle).
//  - Any other {funct7,funct3}: completes in 1 cycle with result=0 and out_illegal=1.
//    The result is never held from a previous op.
//  - FSM: IDLE -> (div op accepted) DIV -> (counter==XLEN) DONE -> IDLE, with out_valid=1 on entering IDLE.
//    A 1-cycle op stays in IDLE.
//    DIV: restoring radix-2 over operand magnitudes, one quotient bit per clk.
//    DONE: sign fix-up and result registered. Div latency is XLEN+2 cycles from accept to out_valid.
//  - Div corner cases bypass iteration and complete in 1 cycle:
//    divisor=0 -> DIV/DIVU=all-ones, REM/REMU=dividend.
//    signed overflow (-2^(XLEN-1) / -1) -> DIV=dividend, REM=0.
//  - Remainder sign follows the dividend. Quotient is truncated toward zero.
// CONFIGURATION
//  ALU_DIV_EN defined: the divider and DIV FSM states are built as above.
//  ALU_DIV_EN undefined: no divider logic; FSM stays in IDLE.
//    DIV/DIVU/REM/REMU complete in 1 cycle with result=0 and out_illegal=1. MUL ops are unaffected.
// STRUCTURE
//  alu_pkg: funct7 constants (F7_BASE, F7_ALT, F7_MULDIV), funct3 op constants, an op-class enum (ALU/MUL/DIV/ILLEGAL),
//    and an FSM state enum (IDLE/DIV/DONE).
//  One sub-module, alu_divider: the iterative magnitude divider with start/busy/done, present only under ALU_DIV_EN.
//  Decode, the combinational ALU/MUL datapath, the handshake, and the output register live in alu_mdu_seq.
// TESTING
//  1. ADD 0x7FFFFFFF+1, then SRA 0x80000000>>>4 issued back-to-back, out_ready=1
//     -> 0x80000000 then 0xF8000000 on consecutive cycles.
//  2. MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
//     out_valid exactly XLEN+2 cycles after accept; in_ready=0 throughout.
//  4. DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000000 % -1 -> 0; DIV 0x80000000 / -1 -> 0x80000000. Each completes in 1 cycle.
//  5. Hold out_ready=0 for 5 cycles after a result -> result stable, in_ready=0. Releasing out_ready accepts the next op that cycle.
//  6. funct7=0000010 -> out_illegal=1, result=0.
//     Assert rst mid-DIV -> out_valid=0 next cycle, in_ready=1 after.
//     Without ALU_DIV_EN, DIV gives out_illegal=1 in 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - encodings, op classes and FSM states for alu_mdu_seq (ALU_DIV_EN selects divider support)
package alu_pkg;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD    = 3'd0;
    localparam logic [2:0] F3_SLL    = 3'd1;
    localparam logic [2:0] F3_SLT    = 3'd2;
    localparam logic [2:0] F3_SLTU   = 3'd3;
    localparam logic [2:0] F3_XOR    = 3'd4;
    localparam logic [2:0] F3_SR     = 3'd5;
    localparam logic [2:0] F3_OR     = 3'd6;
    localparam logic [2:0] F3_AND    = 3'd7;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        OP_ALU,
        OP_MUL,
        OP_DIV,
        OP_ILLEGAL
    } op_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } state_t;

    // F7_ALT is only meaningful for SUB and SRA; everything else under it is illegal
    function automatic op_class_t decode_class(input logic [6:0] f7, input logic [2:0] f3);
        op_class_t cls;
        cls = OP_ILLEGAL;
        if (f7 == F7_BASE) begin
            cls = OP_ALU;
        end else if (f7 == F7_ALT) begin
            if (f3 == F3_ADD || f3 == F3_SR) begin
                cls = OP_ALU;
            end
        end else if (f7 == F7_MULDIV) begin
            if (!f3[2]) begin
                cls = OP_MUL;
            end else begin
`ifdef ALU_DIV_EN
                cls = OP_DIV;
`else
                cls = OP_ILLEGAL;
`endif
            end
        end
        return cls;
    endfunction

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - iterative restoring radix-2 magnitude divider, one quotient bit per clock
module alu_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN);

    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dsr;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    // Trial subtraction of the divisor from the partial remainder with the next dividend bit shifted in
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dsr};
    end

    // Load on start, then iterate until the counter reaches XLEN; results hold once busy drops
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= '0;
            quo   <= '0;
            rem   <= '0;
            dsr   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
            quo   <= dividend;
            rem   <= '0;
            dsr   <= divisor;
        end else if (busy) begin
            if (count == LAST) begin
                busy <= 1'b0;
            end else begin
                count <= count + 1'b1;
                if (!diff[XLEN]) begin
                    rem <= diff[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b1};
                end else begin
                    rem <= shifted[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    assign done      = busy && (count == LAST);
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - handshaked RV32IM execute unit; divider built only when ALU_DIV_EN is defined
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            out_illegal
);

    state_t              state;
    op_class_t           op_class;
    logic                accept;
    logic                go_div;
    logic [SHAMT_W-1:0]  shamt;
    logic [XLEN-1:0]     alu_res;
    logic [XLEN-1:0]     mul_res;
    logic [XLEN-1:0]     fast_result;
    logic                fast_illegal;
    logic                mul_a_signed;
    logic                mul_b_signed;
    logic [2*XLEN-1:0]   mul_a;
    logic [2*XLEN-1:0]   mul_b;
    logic [2*XLEN-1:0]   product;

    assign op_class = decode_class(funct7, funct3);
    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = operand2[SHAMT_W-1:0];

    // Base integer ALU; funct7 bit 5 picks SUB and SRA
    always_comb begin
        alu_res = '0;
        case (funct3)
            F3_ADD:  alu_res = (funct7 == F7_ALT) ? operand1 - operand2 : operand1 + operand2;
            F3_SLL:  alu_res = operand1 << shamt;
            F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, operand1 < operand2};
            F3_XOR:  alu_res = operand1 ^ operand2;
            F3_SR:   alu_res = (funct7 == F7_ALT) ? XLEN'($signed(operand1) >>> shamt) : operand1 >> shamt;
            F3_OR:   alu_res = operand1 | operand2;
            F3_AND:  alu_res = operand1 & operand2;
            default: alu_res = '0;
        endcase
    end

    // One double-width multiplier; operand extension selects signed/unsigned/mixed high products
    always_comb begin
        mul_a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
        mul_b_signed = (funct3 == F3_MULH);
        mul_a   = {{XLEN{mul_a_signed & operand1[XLEN-1]}}, operand1};
        mul_b   = {{XLEN{mul_b_signed & operand2[XLEN-1]}}, operand2};
        product = mul_a * mul_b;
        mul_res = (funct3 == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

`ifdef ALU_DIV_EN
    logic            div_signed;
    logic            div_is_rem;
    logic            div_by_zero;
    logic            div_ovf;
    logic            div_fast;
    logic [XLEN-1:0] div_fast_res;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            neg_q;
    logic            neg_r;
    logic            sel_rem;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;

    // Divide-by-zero and signed overflow resolve immediately; everything else goes to the divider as magnitudes
    always_comb begin
        div_signed   = !funct3[0];
        div_is_rem   = funct3[1];
        div_by_zero  = (operand2 == '0);
        div_ovf      = div_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
        div_fast     = div_by_zero || div_ovf;
        if (div_by_zero) begin
            div_fast_res = div_is_rem ? operand1 : '1;
        end else begin
            div_fast_res = div_is_rem ? '0 : operand1;
        end
        a_neg = div_signed && operand1[XLEN-1];
        b_neg = div_signed && operand2[XLEN-1];
        mag_a = a_neg ? -operand1 : operand1;
        mag_b = b_neg ? -operand2 : operand2;
    end

    assign go_div = (op_class == OP_DIV) && !div_fast;

    alu_divider #(
        .XLEN (XLEN)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && go_div),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    assign go_div = 1'b0;
`endif

    // Result selection for everything that completes in a single cycle
    always_comb begin
        fast_result  = '0;
        fast_illegal = 1'b0;
        case (op_class)
            OP_ALU:     fast_result = alu_res;
            OP_MUL:     fast_result = mul_res;
`ifdef ALU_DIV_EN
            OP_DIV:     fast_result = div_fast_res;
`endif
            default: begin
                fast_result  = '0;
                fast_illegal = 1'b1;
            end
        endcase
    end

    // Control FSM and output register; result and flag only change when a new result is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            out_illegal <= 1'b0;
`ifdef ALU_DIV_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            sel_rem     <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (go_div) begin
                            state <= ST_DIV;
`ifdef ALU_DIV_EN
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            sel_rem <= div_is_rem;
`endif
                        end else begin
                            out_valid   <= 1'b1;
                            result      <= fast_result;
                            out_illegal <= fast_illegal;
                        end
                    end
                end
`ifdef ALU_DIV_EN
                ST_DIV: begin
                    if (div_done) begin
                        state <= ST_DONE;
                    end else if (!div_busy) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    out_valid   <= 1'b1;
                    out_illegal <= 1'b0;
                    if (sel_rem) begin
                        result <= neg_r ? -div_rem : div_rem;
                    end else begin
                        result <= neg_q ? -div_quo : div_quo;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
